// File: rtl/uart_tx_rx_pkg.sv
// Shared definitions for the UART transmitter/receiver pair: state encoding,
// default bit period and the bit-timer counter type.
package uart_tx_rx_pkg;

   // 25 MHz system clock at 115200 baud
   localparam int CLKS_PER_BIT_DEFAULT = 217;

   typedef logic [15:0] timer_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_CLEANUP
   } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter that marks the last cycle of a serial bit period.
// o_Terminal is high whenever the count has reached zero.
module uart_bit_timer
   import uart_tx_rx_pkg::*;
(
   input  logic   i_Clk,
   input  logic   i_Rst,
   input  logic   i_Load,
   input  timer_t i_Load_Value,
   output logic   o_Terminal
);

   timer_t count;

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         count <= '0;
      end else if (i_Load) begin
         count <= i_Load_Value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign o_Terminal = (count == '0);

endmodule

// File: rtl/uart_tx_rx.sv
// 8N1 UART with independent transmit and receive paths sharing one clock.
// Each path is a two-process FSM paced by its own uart_bit_timer.
module uart_tx_rx
   import uart_tx_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_TX_DV,
   input  logic [7:0] i_TX_Byte,
   output logic       o_TX_Active,
   output logic       o_TX_Serial,
   output logic       o_TX_Done,
   input  logic       i_RX_Serial,
   output logic       o_RX_DV,
   output logic [7:0] o_RX_Byte
);

   localparam timer_t BIT_LOAD  = timer_t'(CLKS_PER_BIT - 1);
   localparam timer_t HALF_LOAD = timer_t'((CLKS_PER_BIT - 1) / 2);

   uart_state_e tx_state, tx_state_next;
   logic [7:0]  tx_shift, tx_shift_next;
   logic [2:0]  tx_bit_idx, tx_idx_next;
   logic        tx_load, tx_tc;
   logic        tx_serial_next, tx_active_next, tx_done_next;

   uart_bit_timer tx_timer (
      .i_Clk        (i_Clk),
      .i_Rst        (i_Rst),
      .i_Load       (tx_load),
      .i_Load_Value (BIT_LOAD),
      .o_Terminal   (tx_tc)
   );

   // Line outputs are decoded from the next state and registered so the TX
   // pin never glitches on state transitions.
   always_comb begin
      tx_state_next = tx_state;
      tx_shift_next = tx_shift;
      tx_idx_next   = tx_bit_idx;
      tx_load       = 1'b0;
      case (tx_state)
         ST_IDLE: if (i_TX_DV) begin
            tx_state_next = ST_START;
            tx_shift_next = i_TX_Byte;
            tx_idx_next   = 3'd0;
            tx_load       = 1'b1;
         end
         ST_START: if (tx_tc) begin
            tx_state_next = ST_DATA;
            tx_load       = 1'b1;
         end
         ST_DATA: if (tx_tc) begin
            tx_load       = 1'b1;
            tx_shift_next = {1'b0, tx_shift[7:1]};
            tx_idx_next   = tx_bit_idx + 3'd1;
            if (tx_bit_idx == 3'd7) tx_state_next = ST_STOP;
         end
         ST_STOP: if (tx_tc) tx_state_next = ST_CLEANUP;
         ST_CLEANUP: tx_state_next = ST_IDLE;
         default: tx_state_next = ST_IDLE;
      endcase
      tx_serial_next = 1'b1;
      if (tx_state_next == ST_START) tx_serial_next = 1'b0;
      else if (tx_state_next == ST_DATA) tx_serial_next = tx_shift_next[0];
      tx_active_next = (tx_state_next == ST_START) || (tx_state_next == ST_DATA) ||
                       (tx_state_next == ST_STOP);
      tx_done_next   = (tx_state_next == ST_CLEANUP);
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         tx_state    <= ST_IDLE;
         tx_shift    <= '0;
         tx_bit_idx  <= '0;
         o_TX_Serial <= 1'b1;
         o_TX_Active <= 1'b0;
         o_TX_Done   <= 1'b0;
      end else begin
         tx_state    <= tx_state_next;
         tx_shift    <= tx_shift_next;
         tx_bit_idx  <= tx_idx_next;
         o_TX_Serial <= tx_serial_next;
         o_TX_Active <= tx_active_next;
         o_TX_Done   <= tx_done_next;
      end
   end

   uart_state_e rx_state, rx_state_next;
   logic [1:0]  rx_sync;
   logic        rx_bit;
   logic [2:0]  rx_bit_idx, rx_idx_next;
   logic [7:0]  rx_byte_saved;
   timer_t      rx_load_value;
   logic        rx_load, rx_tc, rx_sample, rx_save, rx_restore, rx_dv_next;

   assign rx_bit = rx_sync[1];

   uart_bit_timer rx_timer (
      .i_Clk        (i_Clk),
      .i_Rst        (i_Rst),
      .i_Load       (rx_load),
      .i_Load_Value (rx_load_value),
      .o_Terminal   (rx_tc)
   );

   // The first wait is half a bit so every later sample lands mid-bit; the
   // old byte is kept aside so a framing error can put it back.
   always_comb begin
      rx_state_next = rx_state;
      rx_idx_next   = rx_bit_idx;
      rx_load       = 1'b0;
      rx_load_value = BIT_LOAD;
      rx_sample     = 1'b0;
      rx_save       = 1'b0;
      rx_restore    = 1'b0;
      rx_dv_next    = 1'b0;
      case (rx_state)
         ST_IDLE: if (!rx_bit) begin
            rx_state_next = ST_START;
            rx_load       = 1'b1;
            rx_load_value = HALF_LOAD;
         end
         ST_START: if (rx_tc) begin
            if (!rx_bit) begin
               rx_state_next = ST_DATA;
               rx_load       = 1'b1;
               rx_save       = 1'b1;
               rx_idx_next   = 3'd0;
            end else begin
               rx_state_next = ST_IDLE;
            end
         end
         ST_DATA: if (rx_tc) begin
            rx_sample = 1'b1;
            rx_load   = 1'b1;
            if (rx_bit_idx == 3'd7) rx_state_next = ST_STOP;
            else rx_idx_next = rx_bit_idx + 3'd1;
         end
         ST_STOP: if (rx_tc) begin
            rx_state_next = ST_CLEANUP;
            rx_dv_next    = rx_bit;
            rx_restore    = !rx_bit;
         end
         ST_CLEANUP: rx_state_next = ST_IDLE;
         default: rx_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         rx_sync       <= 2'b11;
         rx_state      <= ST_IDLE;
         rx_bit_idx    <= '0;
         rx_byte_saved <= '0;
         o_RX_Byte     <= '0;
         o_RX_DV       <= 1'b0;
      end else begin
         rx_sync    <= {rx_sync[0], i_RX_Serial};
         rx_state   <= rx_state_next;
         rx_bit_idx <= rx_idx_next;
         o_RX_DV    <= rx_dv_next;
         if (rx_save) rx_byte_saved <= o_RX_Byte;
         if (rx_sample) o_RX_Byte[rx_bit_idx] <= rx_bit;
         else if (rx_restore) o_RX_Byte <= rx_byte_saved;
      end
   end

endmodule

// File: tb/tb_uart_tx_rx.sv
// Directed and randomized bench for uart_tx_rx: TX waveform model per cycle,
// loopback and directly driven RX frames, glitch/framing/reset scenarios.
module tb_uart_tx_rx;

   localparam int CPB   = 217;
   localparam int FRAME = 10 * CPB;

   logic       i_Clk = 1'b0;
   logic       i_Rst;
   logic       i_TX_DV;
   logic [7:0] i_TX_Byte;
   logic       o_TX_Active;
   logic       o_TX_Serial;
   logic       o_TX_Done;
   logic       i_RX_Serial;
   logic       o_RX_DV;
   logic [7:0] o_RX_Byte;

   logic loopback;
   logic rxDrive;
   int   compared   = 0;
   int   mismatched = 0;
   int   txDoneCount = 0;
   logic [7:0] rxGot[$];
   logic [7:0] rxExp[$];
   logic [7:0] lastRx;

   assign i_RX_Serial = loopback ? o_TX_Serial : rxDrive;

   always #5 i_Clk = ~i_Clk;

   uart_tx_rx #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clk       (i_Clk),
      .i_Rst       (i_Rst),
      .i_TX_DV     (i_TX_DV),
      .i_TX_Byte   (i_TX_Byte),
      .o_TX_Active (o_TX_Active),
      .o_TX_Serial (o_TX_Serial),
      .o_TX_Done   (o_TX_Done),
      .i_RX_Serial (i_RX_Serial),
      .o_RX_DV     (o_RX_DV),
      .o_RX_Byte   (o_RX_Byte)
   );

   always @(negedge i_Clk) begin
      if (o_TX_Done === 1'b1) txDoneCount++;
      if (o_RX_DV === 1'b1) rxGot.push_back(o_RX_Byte);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Sends one byte and compares the TX pins every cycle against the 8N1 frame
   // built from the byte; optionally fires a second request mid-frame.
   task automatic applyStimulus(input logic [7:0] txByte, input int interfereAt,
                                input string tag);
      int         badLine = 0;
      int         badActive = 0;
      int         badDone = 0;
      int         doneBefore;
      logic [9:0] frameBits;
      logic       expLine, expActive, expDone;
      frameBits  = {1'b1, txByte, 1'b0};
      doneBefore = txDoneCount;
      @(negedge i_Clk);
      i_TX_DV   = 1'b1;
      i_TX_Byte = txByte;
      for (int k = 1; k <= FRAME + 2; k++) begin
         @(negedge i_Clk);
         expActive = (k <= FRAME);
         expLine   = expActive ? frameBits[(k - 1) / CPB] : 1'b1;
         expDone   = (k == FRAME + 1);
         if (o_TX_Serial !== expLine) badLine++;
         if (o_TX_Active !== expActive) badActive++;
         if (o_TX_Done !== expDone) badDone++;
         i_TX_DV   = (interfereAt > 0) && (k == interfereAt);
         i_TX_Byte = (k == interfereAt) ? 8'hAA : 8'($urandom);
      end
      i_TX_DV = 1'b0;
      checkOutput({tag, "_line_bad_cycles"}, badLine, 0);
      checkOutput({tag, "_active_bad_cycles"}, badActive, 0);
      checkOutput({tag, "_done_bad_cycles"}, badDone, 0);
      checkOutput({tag, "_done_count"}, txDoneCount - doneBefore, 1);
   endtask

   task automatic driveRxFrame(input logic [7:0] rxByte, input logic stopBit);
      logic [9:0] bits;
      bits = {stopBit, rxByte, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxDrive = bits[i];
         repeat (CPB) @(negedge i_Clk);
      end
      rxDrive = 1'b1;
   endtask

   task automatic checkRxQueue(input string tag);
      checkOutput({tag, "_rx_count"}, rxGot.size(), rxExp.size());
      for (int i = 0; i < rxGot.size() && i < rxExp.size(); i++)
         checkOutput({tag, "_rx_byte"}, rxGot[i], rxExp[i]);
      rxGot.delete();
      rxExp.delete();
   endtask

   initial begin
      logic [7:0] b;
      int doneBefore;
      i_Rst     = 1'b1;
      i_TX_DV   = 1'b0;
      i_TX_Byte = 8'h00;
      loopback  = 1'b1;
      rxDrive   = 1'b1;
      repeat (3) @(negedge i_Clk);
      checkOutput("reset_tx_serial", o_TX_Serial, 1);
      checkOutput("reset_tx_active", o_TX_Active, 0);
      checkOutput("reset_tx_done", o_TX_Done, 0);
      checkOutput("reset_rx_dv", o_RX_DV, 0);
      checkOutput("reset_rx_byte", o_RX_Byte, 8'h00);
      i_Rst = 1'b0;
      repeat (5) @(negedge i_Clk);

      rxExp.push_back(8'h37);
      applyStimulus(8'h37, 0, "loop37");
      repeat (20) @(negedge i_Clk);
      checkRxQueue("loop37");
      lastRx = 8'h37;

      for (int n = 0; n < 4; n++) begin
         b = 8'($urandom);
         rxExp.push_back(b);
         applyStimulus(b, 0, "loop_rand");
         repeat (20) @(negedge i_Clk);
         checkRxQueue("loop_rand");
         lastRx = b;
      end

      $display("[TB] start-bit glitch");
      loopback = 1'b0;
      rxDrive  = 1'b0;
      repeat (50) @(negedge i_Clk);
      rxDrive = 1'b1;
      repeat (300) @(negedge i_Clk);
      checkRxQueue("glitch");
      checkOutput("glitch_rx_byte_held", o_RX_Byte, lastRx);
      b = 8'($urandom);
      rxExp.push_back(b);
      driveRxFrame(b, 1'b1);
      repeat (300) @(negedge i_Clk);
      checkRxQueue("after_glitch");
      lastRx = b;

      $display("[TB] request during frame, then back-to-back");
      loopback = 1'b1;
      rxExp.push_back(8'h00);
      applyStimulus(8'h00, 500, "midframe");
      repeat (20) @(negedge i_Clk);
      checkRxQueue("midframe");
      rxExp.push_back(8'h00);
      rxExp.push_back(8'hFF);
      applyStimulus(8'h00, 0, "b2b_00");
      applyStimulus(8'hFF, 0, "b2b_ff");
      repeat (20) @(negedge i_Clk);
      checkRxQueue("b2b");
      lastRx = 8'hFF;

      $display("[TB] framing error");
      loopback = 1'b0;
      driveRxFrame(8'($urandom), 1'b0);
      repeat (600) @(negedge i_Clk);
      checkRxQueue("framing_err");
      checkOutput("framing_err_byte_restored", o_RX_Byte, lastRx);
      rxExp.push_back(8'h5A);
      driveRxFrame(8'h5A, 1'b1);
      repeat (300) @(negedge i_Clk);
      checkRxQueue("after_framing_err");
      lastRx = 8'h5A;

      $display("[TB] concurrent TX and RX");
      b = 8'($urandom);
      rxExp.push_back(b);
      fork
         applyStimulus(8'($urandom), 0, "concurrent_tx");
         driveRxFrame(b, 1'b1);
      join
      repeat (20) @(negedge i_Clk);
      checkRxQueue("concurrent_rx");

      $display("[TB] reset during data bit 3");
      loopback   = 1'b1;
      doneBefore = txDoneCount;
      @(negedge i_Clk);
      i_TX_DV   = 1'b1;
      i_TX_Byte = 8'($urandom);
      @(negedge i_Clk);
      i_TX_DV = 1'b0;
      repeat (949) @(negedge i_Clk);
      checkOutput("abort_active_before", o_TX_Active, 1);
      i_Rst = 1'b1;
      @(negedge i_Clk);
      checkOutput("abort_tx_serial", o_TX_Serial, 1);
      checkOutput("abort_tx_active", o_TX_Active, 0);
      checkOutput("abort_rx_byte", o_RX_Byte, 8'h00);
      i_Rst = 1'b0;
      repeat (2500) @(negedge i_Clk);
      checkOutput("abort_no_done", txDoneCount - doneBefore, 0);
      checkRxQueue("abort");

      b = 8'($urandom);
      rxExp.push_back(b);
      applyStimulus(b, 0, "recover");
      repeat (20) @(negedge i_Clk);
      checkRxQueue("recover");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
